axi_stream_rr_arbiter: RTL and testbench
========================================

# axi_stream_rr_arbiter

Round-robin N-to-1 AXI-stream arbiter with packet lock. It shares one downstream stream port between N upstream requesters, for example several fork/split branches merging into a common sink. A grant is held from the first beat to the `last` beat of a packet, so packets never interleave. Output `valid` is derived only from registered grant state and upstream `valid`, never from `m_ready`.

## Interface
Parameters:
- `N`, 4: number of requesters; legal range 2..16.
- `DATA_WD`, 8: payload width per beat.
- `ID_WD`, 2: width of the grant index; must satisfy 2^ID_WD >= N.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_valid`, input, N: per-requester valid.
- `s_data`, input, N*DATA_WD: requester i occupies bits [i*DATA_WD +: DATA_WD].
- `s_last`, input, N: per-requester end-of-packet flag.
- `s_ready`, output, N: per-requester ready.
- `m_valid`, output, 1: downstream valid.
- `m_data`, output, DATA_WD: downstream payload.
- `m_last`, output, 1: downstream end-of-packet flag.
- `m_id`, output, ID_WD: index of the requester currently granted.
- `m_ready`, input, 1: downstream ready.

## Operation
- Registered state: `state` in {IDLE, BUSY}, `grant` [ID_WD], `ptr` [ID_WD].
- IDLE:
  - If any `s_valid` is high, select the first index i with `s_valid[i]=1`, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Load `grant<=i` and `state<=BUSY`.
  - Otherwise stay in IDLE.
- BUSY:
  - `m_valid = s_valid[grant]`.
  - `m_data` = slice `grant` of `s_data`; `m_last = s_last[grant]`.
  - `s_ready[grant] = m_ready`.
  - A beat transfers when `m_valid && m_ready`.
  - On a transfer with `m_last=1`: `state<=IDLE`, `ptr<=(grant==N-1)?0:grant+1`.
- In IDLE: `m_valid=0`, `m_last=0`, all `s_ready=0`. `m_data` still drives slice `grant` (content is don't-care).
- Non-granted requesters always see `s_ready=0`.
- `m_id = grant` in both states. It is meaningful only while `m_valid=1`.
- Bubbles inside a packet (granted `s_valid` low) do not release the grant. The arbiter waits indefinitely for `last`.
- No data is stored. The block is a pure mux plus the grant FSM, so there is no full/empty condition.

## Timing
- Reset values:
  - `state=IDLE`, `grant=0`, `ptr=0`.
  - `m_valid=0`, `m_last=0`, `s_ready=0`, `m_id=0`.
- Arbitration latency: a request seen in IDLE at cycle T produces `m_valid=1` at T+1 at the earliest.
- Throughput:
  - Within a packet, one beat per cycle while the granted requester is valid and `m_ready=1`.
  - One idle cycle follows every `last` beat, during the return through IDLE.
  - A packet of L beats occupies at least L+1 cycles.
- Simultaneous requests: exactly one winner per IDLE cycle. The others keep `valid` asserted; AXI rules require that they do not drop it.
- Pointer wrap: a grant to N-1 followed by `last` sets `ptr=0`.
- `rst` mid-packet:
  - Returns to IDLE next cycle with `ptr=0`, and all `s_ready` drop immediately after the edge.
  - The partial packet is truncated downstream; recovery is the upstream's responsibility.
- `m_ready` held low in BUSY: `m_valid` and `m_data` remain stable as long as the upstream holds them, so AXI stability is inherited.
- Valid/ready independence: `m_valid` is not a function of `m_ready`. `s_ready` depends combinationally on `m_ready`, which AXI permits.

## Test plan
- **Reset:** hold `rst=1` with all `s_valid=1` → `m_valid=0` and `s_ready=0` throughout. First release cycle IDLE; `m_valid=1` with `m_id=0` one cycle later.
- **All four requesters** sending continuous 1-beat packets, `m_ready=1` → `m_id` sequence 0,1,2,3,0…, one beat every 2 cycles, each `m_data` equal to the requester's slice.
- **Packet lock:** requester 1 sends a 3-beat packet (last on beat 3) while requester 2 is valid → three beats with `m_id=1`, `s_ready[2]=0` throughout, then after one IDLE cycle `m_id=2`.
- **Backpressure:** `m_ready=0` for 5 cycles mid-packet → `m_valid`, `m_data` and `m_last` are stable, `s_ready[grant]=0`, no beat is lost or duplicated when `m_ready` returns.
- **Fairness and wrap:** grant 3 with `last`, then requesters 0 and 2 both valid → next grant is 0 (`ptr` wrapped to 0). After that packet, requester 2 is granted before any re-request from 0.
- **Reset mid-packet:** assert `rst` on beat 2 of 4 → next cycle `m_valid=0` and `ptr=0`. After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin N-to-1 AXI-stream arbiter. The grant is held from the first beat
// to the last beat of a packet, so packets from different requesters never interleave.
module axi_stream_rr_arbiter #(
  parameter int N       = 4,
  parameter int DATA_WD = 8,
  parameter int ID_WD   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         s_valid,
  input  logic [N*DATA_WD-1:0] s_data,
  input  logic [N-1:0]         s_last,
  output logic [N-1:0]         s_ready,
  output logic                 m_valid,
  output logic [DATA_WD-1:0]   m_data,
  output logic                 m_last,
  output logic [ID_WD-1:0]     m_id,
  input  logic                 m_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ID_WD-1:0] grant, grant_nxt;
  logic [ID_WD-1:0] ptr, ptr_nxt;
  logic [ID_WD-1:0] pick;
  logic             pick_vld;
  logic [ID_WD:0]   scan_sum;
  logic [ID_WD-1:0] scan_idx;
  logic             busy;
  logic             xfer;

  // Rotating-priority scan: ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first valid wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr} + (ID_WD+1)'(k);
      if (scan_sum >= (ID_WD+1)'(N)) scan_sum = scan_sum - (ID_WD+1)'(N);
      scan_idx = scan_sum[ID_WD-1:0];
      if (!pick_vld && s_valid[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Output mux is a pure function of the registered grant; m_ready never feeds m_valid.
  assign busy    = (state == BUSY);
  assign m_id    = grant;
  assign m_data  = s_data[int'(grant)*DATA_WD +: DATA_WD];
  assign m_valid = busy && s_valid[grant];
  assign m_last  = busy && s_last[grant];
  assign xfer    = m_valid && m_ready;

  always_comb begin
    s_ready = '0;
    if (busy) s_ready[grant] = m_ready;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    if (state == IDLE) begin
      if (pick_vld) begin
        grant_nxt = pick;
        state_nxt = BUSY;
      end
    end else if (xfer && s_last[grant]) begin
      state_nxt = IDLE;
      ptr_nxt   = (grant == ID_WD'(N-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Bench for axi_stream_rr_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic against a packet-level reference model.
module tb_axi_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  s_valid = '0;
  logic [N-1:0]  s_last = '0;
  logic [N-1:0]  s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;

  int errors = 0;
  int checks = 0;

  axi_stream_rr_arbiter #(.N(N), .DATA_WD(DW), .ID_WD(IW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_id(m_id), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    s_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = '1; s_last = '1; m_ready = 1'b1;
    s_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1; checks++;
      if (m_valid !== 1'b0 || s_ready !== 4'b0000 || m_last !== 1'b0 || m_id !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold c%0d: m_valid=%b s_ready=%b m_last=%b m_id=%0d, want 0 0000 0 0", c, m_valid, s_ready, m_last, m_id);
      end
      tick();
    end
    rst = 1'b0;
    #1; checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: m_valid=%b want 0", m_valid);
    end
    tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd0 || m_data !== 8'hA0 || s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: m_valid=%b m_id=%0d m_data=%h s_ready=%b want 1 0 a0 0001", m_valid, m_id, m_data, s_ready);
    end
    tick();
  endtask

  task automatic test_all_four();
    logic [IW-1:0] eid;
    logic [DW-1:0] ed;
    logic [N-1:0]  er;
    do_reset();
    s_valid = '1; s_last = '1; m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      eid = IW'(k % 4);
      ed  = 8'hA0 + DW'(k % 4);
      er  = '0; er[eid] = 1'b1;
      #1; checks++;
      if (m_valid !== 1'b0) begin
        errors++; $display("FAIL rr_gap k%0d: m_valid=%b want 0", k, m_valid);
      end
      tick();
      #1; checks++;
      if (m_valid !== 1'b1 || m_id !== eid || m_data !== ed || s_ready !== er || m_last !== 1'b1) begin
        errors++;
        $display("FAIL rr_beat k%0d: m_valid=%b m_id=%0d m_data=%h s_ready=%b want 1 %0d %h %b", k, m_valid, m_id, m_data, s_ready, eid, ed, er);
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    s_valid = 4'b0110; s_last = 4'b0100; m_ready = 1'b1;
    #1; tick();
    for (int b = 0; b < 3; b++) begin
      s_last[1] = (b == 2);
      #1; checks++;
      if (m_valid !== 1'b1 || m_id !== 2'd1 || m_data !== 8'hA1 || m_last !== (b == 2) || s_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_beat b%0d: m_valid=%b m_id=%0d m_data=%h m_last=%b s_ready=%b want 1 1 a1 %b 0010", b, m_valid, m_id, m_data, m_last, s_ready, (b == 2));
      end
      tick();
    end
    s_valid[1] = 1'b0;
    #1; checks++;
    if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
      errors++; $display("FAIL lock_idle: m_valid=%b s_ready=%b want 0 0000", m_valid, s_ready);
    end
    tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd2 || m_data !== 8'hA2 || s_ready !== 4'b0100) begin
      errors++;
      $display("FAIL lock_next: m_valid=%b m_id=%0d m_data=%h s_ready=%b want 1 2 a2 0100", m_valid, m_id, m_data, s_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int beat;
    logic [N-1:0] er;
    logic [DW-1:0] ed;
    do_reset();
    beat = 0;
    s_valid = 4'b1000; s_last = 4'b0000; m_ready = 1'b1;
    s_data[3*DW +: DW] = 8'h30;
    #1; tick();
    for (int c = 0; c < 9; c++) begin
      m_ready = !(c >= 1 && c <= 5);
      ed = 8'h30 + DW'(beat);
      s_data[3*DW +: DW] = ed;
      s_last[3] = (beat == 3);
      er = m_ready ? 4'b1000 : 4'b0000;
      #1; checks++;
      if (m_valid !== 1'b1 || m_id !== 2'd3 || m_data !== ed || m_last !== (beat == 3) || s_ready !== er) begin
        errors++;
        $display("FAIL bp_beat c%0d: m_valid=%b m_id=%0d m_data=%h m_last=%b s_ready=%b want 1 3 %h %b %b", c, m_valid, m_id, m_data, m_last, s_ready, ed, (beat == 3), er);
      end
      if (m_ready) beat++;
      tick();
    end
    s_valid = '0;
    #1; checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_last: m_valid=%b want 0", m_valid);
    end
    tick();
  endtask

  task automatic test_fairness_wrap();
    do_reset();
    s_valid = 4'b1000; s_last = '1; m_ready = 1'b1;
    #1; tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd3) begin
      errors++; $display("FAIL wrap_grant3: m_valid=%b m_id=%0d want 1 3", m_valid, m_id);
    end
    tick();
    s_valid = 4'b0101;
    #1; tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd0 || m_data !== 8'hA0) begin
      errors++; $display("FAIL wrap_to0: m_valid=%b m_id=%0d m_data=%h want 1 0 a0", m_valid, m_id, m_data);
    end
    tick();
    #1; tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd2 || m_data !== 8'hA2 || s_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fair_next2: m_valid=%b m_id=%0d m_data=%h s_ready=%b want 1 2 a2 0100", m_valid, m_id, m_data, s_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    s_valid = 4'b0100; s_last = 4'b0100; m_ready = 1'b1;
    #1; tick();
    #1; tick();
    s_valid = 4'b0001; s_last = 4'b0000;
    #1; tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd0) begin
      errors++; $display("FAIL rmid_beat1: m_valid=%b m_id=%0d want 1 0", m_valid, m_id);
    end
    tick();
    rst = 1'b1;
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd0) begin
      errors++; $display("FAIL rmid_beat2: m_valid=%b m_id=%0d want 1 0", m_valid, m_id);
    end
    tick();
    rst = 1'b0; s_valid = 4'b1010; s_last = '1;
    #1; checks++;
    if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_idle: m_valid=%b s_ready=%b want 0 0000", m_valid, s_ready);
    end
    tick();
    #1; checks++;
    if (m_valid !== 1'b1 || m_id !== 2'd1) begin
      errors++; $display("FAIL rmid_restart: m_valid=%b m_id=%0d want 1 1", m_valid, m_id);
    end
    tick();
  endtask

  // Reference model: at packet level, a free arbiter hands the port to the first
  // requesting index in rotation from the slot after the last finished packet.
  task automatic test_random();
    bit  mb;
    int  mown, mptr, idx;
    int  len[N], bi[N], seq[N], exp_seq[N];
    bit  hs[N];
    logic          ev;
    logic [N-1:0]  er;
    logic [DW-1:0] ed;
    do_reset();
    mb = 0; mown = 0; mptr = 0;
    for (int i = 0; i < N; i++) begin
      len[i] = 1 + int'($urandom % 4); bi[i] = 0; seq[i] = 0; exp_seq[i] = 0;
      s_valid[i] = ($urandom % 3) != 0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        s_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
        s_last[i] = (bi[i] == len[i] - 1);
      end
      m_ready = ($urandom % 4) != 0;
      #1;
      ev = mb && s_valid[mown];
      er = '0;
      if (mb) er[mown] = m_ready;
      ed = {2'(mown), 6'(seq[mown])};
      checks++;
      if (m_valid !== ev || s_ready !== er) begin
        errors++;
        $display("FAIL rnd_ctrl c%0d: m_valid=%b s_ready=%b want %b %b", c, m_valid, s_ready, ev, er);
      end
      if (ev) begin
        checks++;
        if (m_id !== IW'(mown) || m_data !== ed || m_last !== s_last[mown]) begin
          errors++;
          $display("FAIL rnd_data c%0d: m_id=%0d m_data=%h m_last=%b want %0d %h %b", c, m_id, m_data, m_last, mown, ed, s_last[mown]);
        end
        if (m_ready) begin
          checks++;
          if (m_data !== {2'(mown), 6'(exp_seq[mown])}) begin
            errors++;
            $display("FAIL rnd_order c%0d: m_data=%h want %h", c, m_data, {2'(mown), 6'(exp_seq[mown])});
          end
          exp_seq[mown]++;
        end
      end
      for (int i = 0; i < N; i++) hs[i] = s_valid[i] && s_ready[i];
      if (!mb) begin
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (!mb && s_valid[idx]) begin mb = 1; mown = idx; end
        end
      end else if (ev && m_ready && s_last[mown]) begin
        mb = 0; mptr = (mown + 1) % N;
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          seq[i]++;
          if (bi[i] == len[i] - 1) begin bi[i] = 0; len[i] = 1 + int'($urandom % 4); end
          else bi[i]++;
        end
        if (hs[i] || !s_valid[i]) s_valid[i] = ($urandom % 3) != 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_packet_lock();
    test_backpressure();
    test_fairness_wrap();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
